// File: rtl/me_pkg.sv
// me_pkg: shared states, frame sizes and result record for the motion-estimation frame loader
package me_pkg;
  typedef enum logic [2:0] {LOAD_R, LOAD_S, RUN, DRAIN, RESULT} state_e;
  localparam int REF_PIXELS = 256;
  localparam int SRCH_PIXELS = 1024;
  localparam int CORE_RUN_CYCLES = 4112;
  typedef struct packed {
    logic [3:0] motion_x;
    logic [3:0] motion_y;
    logic [7:0] best_dist;
    logic [1:0] err;
  } result_t;
endpackage

// File: rtl/me_pixel_ram.sv
// me_pixel_ram: pixel memory with one synchronous write port and NR combinational read ports
module me_pixel_ram #(
  parameter int DEPTH = 256,
  parameter int NR = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [NR*AW-1:0] raddr_i,
  output logic [NR*8-1:0] rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rdata_o[r*8 +: 8] = mem_q[raddr_i[r*AW +: AW]];
  end
endmodule

// File: rtl/me_frame_loader.sv
// me_frame_loader: loads reference/search pixels, runs the ME core and returns its result on a valid/ready port
module me_frame_loader
  import me_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8191
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       start,
  input  logic       completed,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  input  logic [7:0] BestDist,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_motion_x,
  output logic [3:0] res_motion_y,
  output logic [7:0] res_best_dist,
  output logic [1:0] res_err,
  output logic       busy
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] R_LAST = 10'(REF_PIXELS - 1);
  localparam logic [9:0] S_LAST = 10'(SRCH_PIXELS - 1);
  state_e state_q;
  logic [9:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic start_q, busy_q, res_valid_q, to_q, frm_q, xfer;
  result_t res_q;
  assign in_ready = (state_q == LOAD_R) || (state_q == LOAD_S);
  assign xfer = in_valid && in_ready;
  assign start = start_q;
  assign busy = busy_q;
  assign res_valid = res_valid_q;
  assign res_motion_x = res_q.motion_x;
  assign res_motion_y = res_q.motion_y;
  assign res_best_dist = res_q.best_dist;
  assign res_err = res_q.err;
  me_pixel_ram #(.DEPTH(REF_PIXELS), .NR(1)) u_rmem (
    .clk_i(clock), .we_i(xfer && state_q == LOAD_R), .waddr_i(cnt_q[7:0]), .wdata_i(in_data),
    .raddr_i(AddressR), .rdata_o(R)
  );
  me_pixel_ram #(.DEPTH(SRCH_PIXELS), .NR(2)) u_smem (
    .clk_i(clock), .we_i(xfer && state_q == LOAD_S), .waddr_i(cnt_q), .wdata_i(in_data),
    .raddr_i({AddressS2, AddressS1}), .rdata_o({S2, S1})
  );
  // start stays high through DRAIN so the core's last registered compare lands before capture
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= LOAD_R;
      cnt_q <= '0;
      wd_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      res_valid_q <= 1'b0;
      to_q <= 1'b0;
      frm_q <= 1'b0;
      res_q <= '0;
    end else begin
      case (state_q)
        LOAD_R:
          if (xfer) begin
            if (in_last) begin
              frm_q <= 1'b1;
              cnt_q <= '0;
            end else if (cnt_q == R_LAST) begin
              state_q <= LOAD_S;
              cnt_q <= '0;
            end else cnt_q <= cnt_q + 10'd1;
          end
        LOAD_S:
          if (xfer) begin
            if (cnt_q == S_LAST) begin
              state_q <= RUN;
              cnt_q <= '0;
              wd_q <= '0;
              start_q <= 1'b1;
              busy_q <= 1'b1;
              if (!in_last) frm_q <= 1'b1;
            end else if (in_last) begin
              state_q <= LOAD_R;
              cnt_q <= '0;
              frm_q <= 1'b1;
            end else cnt_q <= cnt_q + 10'd1;
          end
        RUN:
          if (completed) state_q <= DRAIN;
          else if (wd_q == WD_LAST) begin
            to_q <= 1'b1;
            state_q <= DRAIN;
          end else wd_q <= wd_q + WW'(1);
        DRAIN: begin
          state_q <= RESULT;
          start_q <= 1'b0;
          busy_q <= 1'b0;
          res_valid_q <= 1'b1;
          res_q <= '{motion_x: motionX, motion_y: motionY, best_dist: BestDist, err: {frm_q, to_q}};
          frm_q <= 1'b0;
          to_q <= 1'b0;
        end
        RESULT:
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q <= LOAD_R;
          end
        default: state_q <= LOAD_R;
      endcase
    end
endmodule

// File: tb/tb_me_frame_loader.sv
// tb_me_frame_loader: vector table of frames against a stub ME core, plus reset and timeout sequences
module tb_me_frame_loader;
  import me_pkg::*;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, reset2, in_valid, in_last, res_ready;
  logic [7:0] in_data, BestDist, AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [3:0] motionX, motionY;
  logic in_ready, start, completed, res_valid, busy;
  logic [7:0] R, S1, S2, res_best_dist;
  logic [3:0] res_motion_x, res_motion_y;
  logic [1:0] res_err;
  logic completed2 = 1'b0;
  logic in_ready2, start2, res_valid2, busy2;
  logic [7:0] R_2, S1_2, S2_2, res_best_dist2;
  logic [3:0] res_motion_x2, res_motion_y2;
  logic [1:0] res_err2;
  int comp_at = 100000;
  int ccnt = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] rpx [256];
  logic [7:0] spx [1024];
  result_t exp_q [$];
  typedef struct {
    logic [3:0] mx, my;
    int comp_at, frm, hold;
    logic match;
  } vec_t;
  vec_t vt [4];

  me_frame_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .start(start), .completed(completed), .motionX(motionX), .motionY(motionY),
    .BestDist(BestDist), .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .R(R), .S1(S1), .S2(S2), .res_valid(res_valid), .res_ready(res_ready),
    .res_motion_x(res_motion_x), .res_motion_y(res_motion_y), .res_best_dist(res_best_dist),
    .res_err(res_err), .busy(busy)
  );
  me_frame_loader #(.TIMEOUT_CYCLES(100)) dut_to (
    .clock(clock), .reset(reset2), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .start(start2), .completed(completed2), .motionX(motionX), .motionY(motionY),
    .BestDist(BestDist), .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .R(R_2), .S1(S1_2), .S2(S2_2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_motion_x(res_motion_x2), .res_motion_y(res_motion_y2), .res_best_dist(res_best_dist2),
    .res_err(res_err2), .busy(busy2)
  );

  // stub core: cycle count held at 0 while start is low
  always @(posedge clock) ccnt <= start ? ccnt + 1 : 0;
  assign completed = start && (ccnt == comp_at);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic gen(input int k, input logic [3:0] mx, input logic [3:0] my, input logic match);
    for (int i = 0; i < 1024; i++) spx[i] = 8'(i * 7 + (i / 32) * 13 + k * 29);
    for (int i = 0; i < 256; i++)
      rpx[i] = spx[(i / 16 + int'(my)) * 32 + i % 16 + int'(mx)] + ((!match && i % 37 == 0) ? 8'(k + 1) : 8'd0);
  endtask

  function automatic logic [7:0] model_sad(input logic [3:0] mx, input logic [3:0] my);
    int s = 0;
    int d;
    for (int i = 0; i < 256; i++) begin
      d = int'(rpx[i]) - int'(spx[(i / 16 + int'(my)) * 32 + i % 16 + int'(mx)]);
      s += (d < 0) ? -d : d;
    end
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  function automatic logic [7:0] pix(input int i);
    return (i < 256) ? rpx[i] : spx[i - 256];
  endfunction

  task automatic stream(input int n, input int last_idx, input logic second);
    int miss = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = pix(i);
      in_last = (i == last_idx);
      if (!(second ? in_ready2 : in_ready)) miss++;
      @(negedge clock);
    end
    in_last = 1'b0;
    chk("rdy_during_load", miss, 0);
  endtask

  // the stub core's SAD is taken through the DUT read ports
  task automatic stub_sad(input logic [3:0] mx, input logic [3:0] my);
    int s = 0;
    int d;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        AddressR = 8'(r * 16 + c);
        AddressS1 = 10'((r + int'(my)) * 32 + c + int'(mx));
        #1;
        d = int'(R) - int'(S1);
        s += (d < 0) ? -d : d;
      end
    BestDist = (s > 255) ? 8'd255 : 8'(s);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    result_t e, snap, cur;
    int n;
    logic stable;
    gen(k, v.mx, v.my, v.match);
    motionX = v.mx;
    motionY = v.my;
    comp_at = v.comp_at;
    BestDist = 8'h5A;
    if (v.frm == 1) begin
      stream(700, 699, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("early_last_abort", {in_ready, start, busy}, 3'b100);
    end
    e = '{motion_x: v.mx, motion_y: v.my, best_dist: model_sad(v.mx, v.my), err: (v.frm != 0) ? 2'b10 : 2'b00};
    exp_q.push_back(e);
    stream(1280, (v.frm == 2) ? -1 : 1279, 1'b0);
    in_data = 8'hEE;
    chk("load_done", {in_ready, start, busy}, 3'b011);
    in_valid = 1'b0;
    AddressR = 8'd255;
    AddressS1 = 10'd0;
    AddressS2 = 10'd1023;
    #1;
    chk("rmem_last", R, rpx[255]);
    chk("smem_first", S1, spx[0]);
    chk("smem_last", S2, spx[1023]);
    stub_sad(v.mx, v.my);
    @(negedge clock);
    n = 0;
    while (!completed && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("completed_seen", completed, 1);
    @(negedge clock);
    chk("drain", {start, busy, res_valid}, 3'b110);
    @(negedge clock);
    chk("res_valid_lat", {start, busy, res_valid, in_ready}, 4'b0010);
    snap = {res_motion_x, res_motion_y, res_best_dist, res_err};
    stable = 1'b1;
    repeat (v.hold) begin
      @(negedge clock);
      cur = {res_motion_x, res_motion_y, res_best_dist, res_err};
      if (cur !== snap || !res_valid || in_ready || start) stable = 1'b0;
    end
    if (v.hold > 0) chk("hold_stable", stable, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("res_motion", {res_motion_x, res_motion_y}, {e.motion_x, e.motion_y});
    chk("res_best_dist", res_best_dist, e.best_dist);
    chk("res_err", res_err, e.err);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    chk("handshake", {res_valid, in_ready, start}, 3'b010);
  endtask

  initial begin
    int n;
    vt[0] = '{4'd8, 4'd9, 4111, 0, 0, 1'b1};
    vt[1] = '{4'd3, 4'd5, 60, 1, 0, 1'b0};
    vt[2] = '{4'd15, 4'd15, 45, 2, 20, 1'b0};
    vt[3] = '{4'd0, 4'd0, 200, 0, 3, 1'b0};
    reset = 1'b1;
    reset2 = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'd0;
    res_ready = 1'b0;
    motionX = 4'd0;
    motionY = 4'd0;
    BestDist = 8'd0;
    AddressR = 8'd0;
    AddressS1 = 10'd0;
    AddressS2 = 10'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_state", {in_ready, start, busy, res_valid, res_motion_x, res_motion_y, res_best_dist, res_err},
        {1'b1, 3'b000, 18'd0});
    for (int i = 0; i < 4; i++) run_vec(vt[i], i + 1);
    gen(7, 4'd2, 4'd2, 1'b0);
    comp_at = 100000;
    stream(1280, 1279, 1'b0);
    in_valid = 1'b0;
    repeat (50) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_run", {start, busy, in_ready, res_valid}, 4'b0010);
    reset = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);
    reset = 1'b1;
    reset2 = 1'b0;
    @(negedge clock);
    gen(11, 4'd4, 4'd6, 1'b0);
    motionX = 4'd4;
    motionY = 4'd6;
    BestDist = 8'h33;
    stream(1280, 1279, 1'b1);
    in_valid = 1'b0;
    n = 0;
    for (int t = 0; t < 400 && !res_valid2; t++) begin
      if (start2) n++;
      @(negedge clock);
    end
    chk("timeout_start_cycles", n, 101);
    chk("timeout_result", {res_valid2, res_err2, res_motion_x2, res_motion_y2, res_best_dist2},
        {1'b1, 2'b01, 4'd4, 4'd6, 8'h33});
    chk("timeout_idle", {busy2, start2, in_ready2}, 3'b000);
    AddressR = 8'd0;
    AddressS1 = 10'd5;
    AddressS2 = 10'd1000;
    #1;
    chk("timeout_mem", {R_2, S1_2, S2_2}, {rpx[0], spx[5], spx[1000]});
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    chk("timeout_handshake", {res_valid2, in_ready2}, 2'b01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_frame_loader.md
Name: me_frame_loader

Overview:
- Upstream feeder and result collector for the 16x16 full-search motion-estimation core (16-PE array, 32x32 search window).
- Accepts a pixel stream: 256 reference pixels, then 1024 search-window pixels, both row-major. Stores them in internal memories that serve the core's R/S1/S2 read ports.
- Runs the core by holding start high until completed. Captures motionX, motionY and BestDist, and presents them on a valid/ready result port.
- Replaces the standalone ROM_R/ROM_S models in the integrated datapath.

Parameters:
- REF_PIXELS, 256, reference block size in pixels (16x16)
- SRCH_PIXELS, 1024, search window size in pixels (32x32)
- TIMEOUT_CYCLES, 8191, maximum RUN cycles without completed before the block aborts

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel stream valid
- in_ready  out  1  pixel stream ready
- in_data  in  8  pixel value
- in_last  in  1  asserted with the final (1280th) pixel of a frame pair
- start  out  1  to core start; core count is held at 0 while low
- completed  in  1  from core
- motionX  in  4  from core
- motionY  in  4  from core
- BestDist  in  8  from core
- AddressR  in  8  core reference read address
- AddressS1  in  10  core search read address 1
- AddressS2  in  10  core search read address 2
- R  out  8  Rmem[AddressR], combinational
- S1  out  8  Smem[AddressS1], combinational
- S2  out  8  Smem[AddressS2], combinational
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_motion_x  out  4  captured motionX
- res_motion_y  out  4  captured motionY
- res_best_dist  out  8  captured BestDist
- res_err  out  2  bit0 timeout, bit1 framing error
- busy  out  1  high in RUN/DRAIN

Behaviour:
- Reset (synchronous):
  - state goes to LOAD_R; pixel counter 0; watchdog 0.
  - start=0, res_valid=0, res_* =0, busy=0.
  - Memory contents are not cleared.
  - Reset mid-RUN drops start the same edge, which also resets the core.
- A transfer occurs when in_valid && in_ready. in_ready=1 only in LOAD_R and LOAD_S.
- LOAD_R:
  - Each transfer writes Rmem[cnt] and increments cnt.
  - At cnt==REF_PIXELS-1 the transfer moves to LOAD_S and cnt goes to 0.
- LOAD_S:
  - Each transfer writes Smem[cnt].
  - A transfer at cnt==SRCH_PIXELS-1 goes to RUN.
- Framing:
  - in_last on any transfer other than the 1280th sets the framing flag, and the block returns to LOAD_R with cnt 0 (frame discarded).
  - Missing in_last on the 1280th pixel sets the framing flag but still proceeds to RUN.
  - The flag is reported in res_err[1] of the next result, then cleared.
- RUN:
  - start=1, busy=1, watchdog increments each cycle.
  - completed==1 goes to DRAIN.
  - watchdog==TIMEOUT_CYCLES-1 without completed sets the timeout flag and goes to DRAIN.
- DRAIN (1 cycle):
  - start stays 1 so the comparator's final registered update settles.
  - Next edge captures motionX/motionY/BestDist into res_*, sets res_err, sets res_valid=1, goes to RESULT.
- RESULT:
  - start=0, holding the core count at 0 and re-initialising BestDist.
  - res_* stable while res_valid && !res_ready.
  - res_valid && res_ready clears res_valid and goes to LOAD_R.
  - Minimum gap of 1 start-low cycle between runs is guaranteed.
- Memory ports:
  - Reads are combinational, read-during-write returns old data.
  - Writes occur only in LOAD states; the core is idle then, so no conflict.
  - Out-of-range addresses cannot occur (widths exact).
- Latency:
  - 1280 transfer cycles minimum for the load.
  - RUN is about 4112 cycles.
  - +1 cycle DRAIN, +1 cycle to res_valid.

Decomposition:
- Package me_pkg holds:
  - state enum {LOAD_R, LOAD_S, RUN, DRAIN, RESULT}
  - constants REF_PIXELS, SRCH_PIXELS, CORE_RUN_CYCLES=4112
  - result struct {motion_x, motion_y, best_dist, err}
- One sub-module, me_pixel_ram: parameterised depth, 1 sync write port, N combinational read ports. Instantiated twice: Rmem with 1 read port, Smem with 2 read ports.

Test Plan:
- Reset, then stream 1280 pixels with in_valid always 1 -> in_ready drops after pixel 1280, start rises the next cycle; Rmem[255] and Smem[1023] hold the last written values.
- Reference equals the search window at offset (x=8,y=9) with other pixels distinct, stub core asserts completed at cycle 4111 -> res_best_dist=0x00, res_motion_x/y = core values, res_err=0, res_valid 2 cycles after completed.
- in_last asserted on pixel 700 -> in_ready stays 1, state LOAD_R, start never rises; next clean frame's result has res_err=2'b10.
- Core never asserts completed, TIMEOUT_CYCLES=100 -> start high exactly 101 cycles, then res_valid with res_err[0]=1.
- res_ready held 0 for 20 cycles -> res_* stable, in_ready=0, start=0; res_ready=1 gives one handshake, then in_ready=1 the following cycle.
- reset pulsed at RUN cycle 50 -> start=0 the next cycle, busy=0, in_ready=1, res_valid=0.
